// File: rtl/pipeline_sequencer_if.sv
// Fetch/issue bus between the front end, the sequencer and the datapath.
interface pipeline_sequencer_if;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        be_ps;
  logic        instr_ready;
  logic [31:0] issue_instr;
  logic        issue_valid;
  logic [31:0] pc;
  logic        flush;
  logic        stall;
  logic [15:0] bubble_count;

  modport master (
    output instruction, instr_valid, be_ps,
    input  instr_ready, issue_instr, issue_valid, pc, flush, stall, bubble_count
  );

  modport slave (
    input  instruction, instr_valid, be_ps,
    output instr_ready, issue_instr, issue_valid, pc, flush, stall, bubble_count
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// In-order issue sequencer: RAW hazard bubbles against a two-slot
// EX/WB scoreboard, BEQ redirect with one flush and one recovery bubble.
module pipeline_sequencer (
  input  logic                 clk_ps,
  input  logic                 rst_n_ps,
  pipeline_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {RUN, STALL, REDIRECT} state_e;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  wa;
    logic        is_beq;
    logic [31:0] target;
  } slot_t;

  localparam logic [5:0] OP_BEQ = 6'b000100;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] bubble_count_q, bubble_count_d;
  slot_t       s1_q, s1_d;
  slot_t       s2_q, s2_d;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic        reads_rs, reads_rt, writes;
  logic [4:0]  waddr;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        s2_unused;

  assign opcode = bus.instruction[31:26];
  assign rs     = bus.instruction[25:21];
  assign rt     = bus.instruction[20:16];
  assign rd     = bus.instruction[15:11];

  function automatic logic slot_hit(input logic [4:0] r, input slot_t s);
    return (r != '0) && s.valid && s.we && (s.wa == r);
  endfunction

  // Decode source/destination usage of the fetched word.
  always_comb begin
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    writes   = 1'b0;
    waddr    = '0;
    unique case (opcode)
      6'b000000: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
        writes   = 1'b1;
        waddr    = rd;
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b100011: begin
        reads_rs = 1'b1;
        writes   = 1'b1;
        waddr    = rt;
      end
      6'b101011, OP_BEQ: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
      default: ;
    endcase
    if (waddr == '0) writes = 1'b0;
  end

  // Hazard detection, branch resolution and branch target arithmetic.
  always_comb begin
    hazard = (reads_rs && (slot_hit(rs, s1_q) || slot_hit(rs, s2_q))) ||
             (reads_rt && (slot_hit(rt, s1_q) || slot_hit(rt, s2_q)));
    branch_taken  = bus.be_ps && s1_q.valid && s1_q.is_beq;
    branch_target = pc_q + 32'd4 +
                    {{14{bus.instruction[15]}}, bus.instruction[15:0], 2'b00};
    s2_unused     = ^{s2_q.is_beq, s2_q.target};
  end

  // Next-state and issue outputs; a taken branch outranks everything else.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    bubble_count_d   = bubble_count_q;
    s2_d             = s1_q;
    s1_d             = '0;
    bus.issue_instr  = '0;
    bus.issue_valid  = 1'b0;
    bus.instr_ready  = 1'b0;
    bus.flush        = 1'b0;
    bus.stall        = 1'b0;

    if (branch_taken) begin
      bus.flush       = 1'b1;
      bus.instr_ready = 1'b1;
      pc_d            = s1_q.target;
      state_d         = REDIRECT;
    end else if (state_q == REDIRECT) begin
      state_d = RUN;
    end else if (bus.instr_valid && !hazard) begin
      bus.issue_instr = bus.instruction;
      bus.issue_valid = 1'b1;
      bus.instr_ready = 1'b1;
      s1_d.valid      = 1'b1;
      s1_d.we         = writes;
      s1_d.wa         = waddr;
      s1_d.is_beq     = (opcode == OP_BEQ);
      s1_d.target     = branch_target;
      pc_d            = pc_q + 32'd4;
      state_d         = RUN;
    end else if (bus.instr_valid) begin
      bus.stall = 1'b1;
      state_d   = STALL;
      if (bubble_count_q != '1) bubble_count_d = bubble_count_q + 16'd1;
    end else begin
      state_d = RUN;
    end

    // Reset suppresses every handshake output so nothing partially issues.
    if (!rst_n_ps) begin
      bus.issue_instr = '0;
      bus.issue_valid = 1'b0;
      bus.instr_ready = 1'b0;
      bus.flush       = 1'b0;
      bus.stall       = 1'b0;
    end

    bus.pc           = pc_q;
    bus.bubble_count = bubble_count_q;
  end

  // State, pc, counter and scoreboard registers.
  always_ff @(posedge clk_ps) begin
    if (!rst_n_ps) begin
      state_q        <= RUN;
      pc_q           <= '0;
      bubble_count_q <= '0;
      s1_q           <= '0;
      s2_q           <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      bubble_count_q <= bubble_count_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench: the stimulus process runs a cycle-level reference of
// the sequencing rules and queues the expected outputs; a negedge monitor
// pops and compares.
module tb_pipeline_sequencer;

  logic clk_ps = 1'b0;
  logic rst_n_ps;

  pipeline_sequencer_if bus();

  pipeline_sequencer dut (
    .clk_ps   (clk_ps),
    .rst_n_ps (rst_n_ps),
    .bus      (bus)
  );

  always #5 clk_ps = ~clk_ps;

  typedef struct {
    logic [31:0] issue_instr;
    logic        issue_valid;
    logic        instr_ready;
    logic        flush;
    logic        stall;
    logic [31:0] pc;
    logic [15:0] bc;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] imem [logic [31:0]];
  bit          directed;

  // Reference state: pc, bubble counter, whether a redirect bubble is due,
  // registers written by the last two issued instructions (0 = none), and
  // whether the most recently issued instruction was a BEQ plus its target.
  logic [31:0] m_pc;
  int          m_bc;
  bit          m_redirect;
  int          m_wr_hist[$];
  bit          m_last_beq;
  logic [31:0] m_last_tgt;
  int          cyc = 0;

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int funct);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic int dest_of(logic [31:0] ins);
    case (ins[31:26])
      6'b000000: return int'(ins[15:11]);
      6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b100011: return int'(ins[20:16]);
      default: return 0;
    endcase
  endfunction

  function automatic bit reads_reg(logic [31:0] ins, int r);
    int s = int'(ins[25:21]);
    int t = int'(ins[20:16]);
    case (ins[31:26])
      6'b000000, 6'b101011, 6'b000100: return (r == s) || (r == t);
      6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b100011: return r == s;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [10];
    ops = '{6'b000000, 6'b000000, 6'b001000, 6'b001100, 6'b001101,
            6'b001010, 6'b100011, 6'b101011, 6'b000100, 6'b111111};
    return {ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            11'($urandom)};
  endfunction

  function automatic logic [31:0] fetch(logic [31:0] addr);
    if (!imem.exists(addr)) imem[addr] = directed ? 32'h0 : rand_instr();
    return imem[addr];
  endfunction

  task automatic model_reset();
    m_pc       = '0;
    m_bc       = 0;
    m_redirect = 1'b0;
    m_wr_hist.delete();
    m_last_beq = 1'b0;
    m_last_tgt = '0;
  endtask

  task automatic record(int dest, bit beq, logic [31:0] tgt);
    m_wr_hist.push_front(dest);
    if (m_wr_hist.size() > 2) void'(m_wr_hist.pop_back());
    m_last_beq = beq;
    m_last_tgt = tgt;
  endtask

  // One clock of stimulus plus the reference prediction for that cycle.
  task automatic step(bit rst, bit iv, bit be);
    logic [31:0] ins;
    exp_t        e;
    bit          hz;
    @(posedge clk_ps);
    #1;
    ins             = fetch(m_pc);
    rst_n_ps        = !rst;
    bus.instruction = ins;
    bus.instr_valid = iv;
    bus.be_ps       = be;
    e = '{issue_instr: 32'h0, issue_valid: 1'b0, instr_ready: 1'b0,
          flush: 1'b0, stall: 1'b0, pc: m_pc, bc: 16'(m_bc), cyc: cyc};
    hz = 1'b0;
    foreach (m_wr_hist[k]) if (m_wr_hist[k] != 0 && reads_reg(ins, m_wr_hist[k])) hz = 1'b1;
    if (rst) begin
      model_reset();
    end else if (be && m_last_beq) begin
      e.flush       = 1'b1;
      e.instr_ready = 1'b1;
      m_pc          = m_last_tgt;
      m_redirect    = 1'b1;
      record(0, 1'b0, '0);
    end else if (m_redirect) begin
      m_redirect = 1'b0;
      record(0, 1'b0, '0);
    end else if (iv && !hz) begin
      e.issue_instr = ins;
      e.issue_valid = 1'b1;
      e.instr_ready = 1'b1;
      record(dest_of(ins), ins[31:26] == 6'b000100,
             m_pc + 32'd4 + 32'($signed(ins[15:0]) * 4));
      m_pc = m_pc + 32'd4;
    end else if (iv) begin
      e.stall = 1'b1;
      if (m_bc < 65535) m_bc++;
      record(0, 1'b0, '0);
    end else begin
      record(0, 1'b0, '0);
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req, int c);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, required %h", name, c, act, req);
    end
  endtask

  // Monitor: compare every presented cycle against the queued prediction.
  always @(negedge clk_ps) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("issue_instr",  bus.issue_instr,          e.issue_instr,          e.cyc);
      chk("issue_valid",  32'(bus.issue_valid),     32'(e.issue_valid),     e.cyc);
      chk("instr_ready",  32'(bus.instr_ready),     32'(e.instr_ready),     e.cyc);
      chk("flush",        32'(bus.flush),           32'(e.flush),           e.cyc);
      chk("stall",        32'(bus.stall),           32'(e.stall),           e.cyc);
      chk("pc",           bus.pc,                   e.pc,                   e.cyc);
      chk("bubble_count", 32'(bus.bubble_count),    32'(e.bc),              e.cyc);
      chk("flush_and_stall", 32'(bus.flush & bus.stall), 32'h0,             e.cyc);
    end
  end

  task automatic new_test();
    imem.delete();
    directed = 1'b1;
    step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n_ps        = 1'b0;
    bus.instruction = '0;
    bus.instr_valid = 1'b0;
    bus.be_ps       = 1'b0;
    directed        = 1'b1;
    repeat (2) @(posedge clk_ps);
    model_reset();

    // Independent stream.
    new_test();
    imem[32'd0] = enc_r(1, 2, 3, 32'h20);
    imem[32'd4] = enc_r(4, 5, 6, 32'h25);
    repeat (4) step(1'b0, 1'b1, 1'b0);

    // Dependent pair: two bubbles then SUB issues.
    new_test();
    imem[32'd0] = enc_r(1, 2, 3, 32'h20);
    imem[32'd4] = enc_r(3, 1, 4, 32'h22);
    repeat (6) step(1'b0, 1'b1, 1'b0);

    // Register 0 never creates a dependency.
    new_test();
    imem[32'd0] = enc_r(1, 2, 0, 32'h20);
    imem[32'd4] = enc_r(0, 0, 5, 32'h20);
    repeat (4) step(1'b0, 1'b1, 1'b0);

    // Taken BEQ at pc 8 with imm 3 redirects to 24.
    new_test();
    imem[32'd8] = enc_i(6'b000100, 0, 0, 16'd3);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b0);

    // Branch wins over a hazard on the fetched word.
    new_test();
    imem[32'd0] = enc_r(1, 2, 3, 32'h20);
    imem[32'd4] = enc_i(6'b000100, 0, 0, 16'd2);
    imem[32'd8] = enc_r(3, 1, 4, 32'h22);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b0);

    // Backward branch to 0xFFFFFFFC, then pc wraps to 0.
    new_test();
    imem[32'd4] = enc_i(6'b000100, 0, 0, 16'hFFFD);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b0);

    // Reset during a stall, be_ps afterwards is ignored.
    new_test();
    imem[32'd0] = enc_r(1, 2, 3, 32'h20);
    imem[32'd4] = enc_r(3, 1, 4, 32'h22);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b0);

    // Reset with a branch pending discards it.
    new_test();
    imem[32'd0] = enc_i(6'b000100, 0, 0, 16'd7);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b0);

    // Randomized traffic.
    new_test();
    directed = 1'b0;
    imem.delete();
    for (int i = 0; i < 3000; i++) begin
      bit r, v, b;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 99) < 85);
      b = m_last_beq ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      step(r, v, b);
    end

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk_ps);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-low, with ports named in the codebase style as clk_ps and rst_n_ps.
REQ-002 Ports SHALL be exactly as follows:
- clk_ps  input  1  rising-edge clock
- rst_n_ps  input  1  synchronous active-low reset
- instruction  input  32  fetched instruction at address pc
- instr_valid  input  1  instruction is valid this cycle
- be_ps  input  1  branch-equal taken, from datapath (branch control AND zero)
- instr_ready  output  1  instruction consumed this cycle
- issue_instr  output  32  instruction driven to datapath; 32'h0000_0000 when bubble
- issue_valid  output  1  issue_instr is a real instruction
- pc  output  32  current fetch address
- flush  output  1  redirect pulse; fetched word discarded
- stall  output  1  hazard bubble inserted this cycle
- bubble_count  output  16  saturating count of hazard bubbles

Function
REQ-003 Decode SHALL be as follows; rd/rt/rs are [15:11]/[20:16]/[25:21].
- opcode 000000: reads rs and rt, writes rd.
- 001000, 001100, 001101, 001010: read rs, write rt.
- 100011 (LW): reads rs, writes rt.
- 101011 (SW) and 000100 (BEQ): read rs and rt, no write.
- Any other opcode: no reads, no write.
- A write to register 0 SHALL be treated as no write.
REQ-004 A two-slot scoreboard SHALL track in-flight writers:
- s1 = EX stage, s2 = WB stage.
- Each slot holds valid, we, wa[4:0], is_beq, and a branch target.
- Every cycle: s2 <= s1, and s1 <= the issued instruction (or an empty slot on a bubble).
REQ-005 RAW hazard SHALL be asserted when a decoded source register is nonzero and equals wa of any slot with valid & we (s1 or s2).
REQ-006 The FSM SHALL have states RUN, STALL and REDIRECT; the reset state is RUN.
REQ-007 In RUN or STALL with instr_valid=1 and no hazard, the block SHALL:
- issue the instruction (issue_instr = instruction, issue_valid = 1, instr_ready = 1);
- advance pc by 4;
- go to RUN.
REQ-008 With instr_valid=1 and a hazard, the block SHALL:
- issue a bubble (issue_instr = 0, issue_valid = 0);
- drive instr_ready = 0 and stall = 1;
- hold pc;
- go to STALL.
- This gives at most 2 consecutive bubbles per hazard.
REQ-009 With instr_valid=0, the block SHALL issue a bubble with stall=0 and hold pc; bubble_count is not incremented.
REQ-010 be_ps SHALL be honoured only when s1.valid & s1.is_beq; otherwise it is ignored.
REQ-011 When be_ps is honoured:
- flush = 1 and instr_ready = 1, so the fetched word is discarded;
- a bubble is issued;
- pc <= s1 target, where target = (branch pc + 4) + (sign-extended imm[15:0] << 2), computed modulo 2^32 at issue;
- the FSM goes to REDIRECT.
REQ-012 A branch SHALL take priority over a hazard and over instr_valid in the same cycle.
REQ-013 In REDIRECT, the block SHALL issue one bubble with instr_ready = 0 and stall = 0, hold pc, then go to RUN.
REQ-014 flush and stall SHALL be combinational on current state and inputs and SHALL never both be 1.
REQ-015 bubble_count SHALL increment on each cycle with stall = 1 and SHALL saturate at 16'hFFFF.
REQ-016 pc SHALL wrap modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
REQ-017 Issue-to-register-bank-write latency SHALL be 2 cycles, matching the datapath's two-stage write-back buffering.

Reset
REQ-018 While rst_n_ps = 0 at a rising edge, the block SHALL set:
- state = RUN, pc = 0, bubble_count = 0;
- both slots invalid;
- issue_instr = 0, issue_valid = 0, instr_ready = 0, flush = 0, stall = 0.
REQ-019 A reset asserted mid-stall or mid-redirect SHALL discard all in-flight state, including any pending branch, with no partial issue.

Verification
REQ-020 Independent stream: ADD r3,r1,r2 followed by OR r6,r4,r5, with instr_valid held high -> both issue on consecutive cycles, pc goes 0 -> 4 -> 8, stall never asserted.
REQ-021 Dependent pair: ADD r3,r1,r2 then SUB r4,r3,r1 -> 2 stall cycles with issue_instr = 0 and pc held at 4; SUB issues on the 3rd cycle; bubble_count = 2.
REQ-022 Register-0 case: ADD r0,r1,r2 then ADD r5,r0,r0 -> no stall.
REQ-023 Branch: BEQ at pc = 8 with imm = 3, be_ps = 1 the next cycle -> flush = 1 for 1 cycle, pc = 24, one REDIRECT bubble, then fetch resumes at 24.
REQ-024 Branch with hazard: be_ps high while the fetched word has a hazard -> flush = 1, stall = 0, bubble_count unchanged.
REQ-025 Reset during STALL -> the next cycle has pc = 0, issue_valid = 0, bubble_count = 0, state = RUN; be_ps asserted on the following cycle is ignored.
